// File: rtl/mac_accumulate.sv
// -----------------------------------------------------------------------------
// mac_accumulate
//   Signed dot-product accumulator feeding requantize_relu. Accepts one
//   int8 activation/weight pair per i_valid beat, accumulates VEC_LEN products
//   per output and emits the sum together with the bias captured on the first
//   beat of that vector as a single-cycle o_valid pulse.
//
//   Pipeline: stage 1 registers the product plus first/last/bias tags,
//   stage 2 adds into the accumulator and launches the output registers.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   i_clear   in   synchronous abort of the current partial vector (wins over i_valid)
//   i_valid   in   i_data/i_weight/i_bias valid this cycle (no backpressure)
//   i_data    in   DATA_W signed activation
//   i_weight  in   DATA_W signed weight
//   i_bias    in   BIAS_W signed bias, sampled on the first beat of a vector
//   o_valid   out  one-cycle pulse, o_acc/o_bias valid
//   o_acc     out  ACC_W signed dot product (holds between pulses)
//   o_bias    out  BIAS_W bias belonging to o_acc (holds between pulses)
//   o_busy    out  partial vector in flight (count non-zero or stage 1 occupied)
//
// Configuration
//   MAC_SAT_EN  defined: stage-2 add saturates to the signed ACC_W range.
//               undefined: plain two's-complement wrap.
// -----------------------------------------------------------------------------
module mac_accumulate #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int BIAS_W  = 32,
  parameter int VEC_LEN = 64,
  parameter int CNT_W   = $clog2(VEC_LEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_weight,
  input  logic [BIAS_W-1:0] i_bias,
  output logic              o_valid,
  output logic [ACC_W-1:0]  o_acc,
  output logic [BIAS_W-1:0] o_bias,
  output logic              o_busy
);

  localparam int              PROD_W   = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

`ifdef MAC_SAT_EN
  // Signed add with clamp to [-(2**(ACC_W-1)), 2**(ACC_W-1)-1].
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction
`endif

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     p1_valid_q, p1_valid_d;
  logic                     p1_first_q, p1_first_d;
  logic                     p1_last_q, p1_last_d;
  logic signed [PROD_W-1:0] p1_prod_q, p1_prod_d;
  logic [BIAS_W-1:0]        p1_bias_q, p1_bias_d;
  logic [BIAS_W-1:0]        bias_hold_q, bias_hold_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic                     o_valid_q, o_valid_d;
  logic [ACC_W-1:0]         o_acc_q, o_acc_d;
  logic [BIAS_W-1:0]        o_bias_q, o_bias_d;
  logic                     busy_q, busy_d;

  logic signed [PROD_W-1:0] data_ext_s, weight_ext_s;
  logic                     first_s, last_s;
  logic [ACC_W-1:0]         prod_ext_s, acc_base_s, acc_next_s;

  // Stage 1: multiply, tag first/last beat, advance the beat counter.
  always_comb begin
    data_ext_s   = $signed({{DATA_W{i_data[DATA_W-1]}}, i_data});
    weight_ext_s = $signed({{DATA_W{i_weight[DATA_W-1]}}, i_weight});
    first_s      = (cnt_q == {CNT_W{1'b0}});
    last_s       = (cnt_q == CNT_LAST);
    cnt_d        = cnt_q;
    p1_valid_d   = 1'b0;
    p1_first_d   = p1_first_q;
    p1_last_d    = p1_last_q;
    p1_prod_d    = p1_prod_q;
    p1_bias_d    = p1_bias_q;
    bias_hold_d  = bias_hold_q;
    if (i_clear) begin
      cnt_d      = {CNT_W{1'b0}};
      p1_valid_d = 1'b0;
    end else if (i_valid) begin
      p1_valid_d = 1'b1;
      p1_prod_d  = data_ext_s * weight_ext_s;
      p1_first_d = first_s;
      p1_last_d  = last_s;
      // The bias travels with the product so a back-to-back vector can
      // overwrite bias_hold while stage 2 still finishes the previous one.
      p1_bias_d  = first_s ? i_bias : bias_hold_q;
      if (first_s) begin
        bias_hold_d = i_bias;
      end else begin
        bias_hold_d = bias_hold_q;
      end
      cnt_d = last_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stage 2: accumulate; a first-beat product restarts the sum.
  always_comb begin
    prod_ext_s = {{(ACC_W-PROD_W){p1_prod_q[PROD_W-1]}}, p1_prod_q};
    acc_base_s = p1_first_q ? {ACC_W{1'b0}} : acc_q;
`ifdef MAC_SAT_EN
    acc_next_s = sat_add(acc_base_s, prod_ext_s);
`else
    acc_next_s = acc_base_s + prod_ext_s;
`endif
    acc_d     = acc_q;
    o_valid_d = 1'b0;
    o_acc_d   = o_acc_q;
    o_bias_d  = o_bias_q;
    if (p1_valid_q) begin
      acc_d = acc_next_s;
      if (p1_last_q) begin
        o_valid_d = 1'b1;
        o_acc_d   = acc_next_s;
        o_bias_d  = p1_bias_q;
      end else begin
        o_valid_d = 1'b0;
      end
    end else begin
      acc_d = acc_q;
    end
    busy_d = (cnt_d != {CNT_W{1'b0}}) || p1_valid_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= {CNT_W{1'b0}};
      p1_valid_q  <= 1'b0;
      p1_first_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      p1_prod_q   <= {PROD_W{1'b0}};
      p1_bias_q   <= {BIAS_W{1'b0}};
      bias_hold_q <= {BIAS_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      o_valid_q   <= 1'b0;
      o_acc_q     <= {ACC_W{1'b0}};
      o_bias_q    <= {BIAS_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      p1_valid_q  <= p1_valid_d;
      p1_first_q  <= p1_first_d;
      p1_last_q   <= p1_last_d;
      p1_prod_q   <= p1_prod_d;
      p1_bias_q   <= p1_bias_d;
      bias_hold_q <= bias_hold_d;
      acc_q       <= acc_d;
      o_valid_q   <= o_valid_d;
      o_acc_q     <= o_acc_d;
      o_bias_q    <= o_bias_d;
      busy_q      <= busy_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_acc   = o_acc_q;
  assign o_bias  = o_bias_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_mac_accumulate.sv
// Self-checking bench for mac_accumulate. Two instances share data/weight/bias/clear:
// u_a (ACC_W=32, VEC_LEN=4) and u_b (ACC_W=17, VEC_LEN=8), each with its own i_valid.
// Expected results come from an arithmetic model of the dot product.
module tb_mac_accumulate;

  localparam int VL_A = 4;
  localparam int VL_B = 8;
  localparam int AW_A = 32;
  localparam int AW_B = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_clear = 1'b0;
  logic        val_a = 1'b0;
  logic        val_b = 1'b0;
  logic [7:0]  i_data = 8'd0;
  logic [7:0]  i_weight = 8'd0;
  logic [31:0] i_bias = 32'd0;
  logic        o_valid_a, o_busy_a, o_valid_b, o_busy_b;
  logic [31:0] o_acc_a, o_bias_a, o_bias_b;
  logic [16:0] o_acc_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  longint exp_acc_a[$], exp_bias_a[$], got_acc_a[$], got_bias_a[$];
  longint exp_acc_b[$], exp_bias_b[$], got_acc_b[$], got_bias_b[$];
  int     got_cyc_a[$];

  int     m_cnt[2];
  longint m_sum[2];
  longint m_bias[2];

  mac_accumulate #(.DATA_W(8), .ACC_W(AW_A), .BIAS_W(32), .VEC_LEN(VL_A)) u_a (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_valid(val_a), .i_data(i_data),
    .i_weight(i_weight), .i_bias(i_bias), .o_valid(o_valid_a), .o_acc(o_acc_a),
    .o_bias(o_bias_a), .o_busy(o_busy_a));

  mac_accumulate #(.DATA_W(8), .ACC_W(AW_B), .BIAS_W(32), .VEC_LEN(VL_B)) u_b (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_valid(val_b), .i_data(i_data),
    .i_weight(i_weight), .i_bias(i_bias), .o_valid(o_valid_b), .o_acc(o_acc_b),
    .o_bias(o_bias_b), .o_busy(o_busy_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid_a) begin
        got_acc_a.push_back(longint'($signed(o_acc_a)));
        got_bias_a.push_back(longint'($signed(o_bias_a)));
        got_cyc_a.push_back(cyc);
      end
      if (o_valid_b) begin
        got_acc_b.push_back(longint'($signed(o_acc_b)));
        got_bias_b.push_back(longint'($signed(o_bias_b)));
      end
    end
  end

  // Reduce a mathematical sum to what a w-bit signed accumulator holds.
  function automatic longint fit(input longint v, input int w);
    longint m, half;
    m = longint'(1) << w;
    half = m / 2;
`ifdef MAC_SAT_EN
    if (v > half - 1) return half - 1;
    if (v < -half) return -half;
    return v;
`else
    v = v % m;
    if (v >= half) v = v - m;
    if (v < -half) v = v + m;
    return v;
`endif
  endfunction

  function automatic void model_beat(input int k, input int d, input int w, input int b);
    if (m_cnt[k] == 0) begin
      m_sum[k]  = 0;
      m_bias[k] = longint'(b);
    end
    m_sum[k] = fit(m_sum[k] + longint'(d * w), (k == 0) ? AW_A : AW_B);
    m_cnt[k]++;
    if (m_cnt[k] == ((k == 0) ? VL_A : VL_B)) begin
      m_cnt[k] = 0;
      if (k == 0) begin
        exp_acc_a.push_back(m_sum[k]);
        exp_bias_a.push_back(m_bias[k]);
      end else begin
        exp_acc_b.push_back(m_sum[k]);
        exp_bias_b.push_back(m_bias[k]);
      end
    end
  endfunction

  task automatic clear_q();
    exp_acc_a.delete(); exp_bias_a.delete(); got_acc_a.delete(); got_bias_a.delete();
    exp_acc_b.delete(); exp_bias_b.delete(); got_acc_b.delete(); got_bias_b.delete();
    got_cyc_a.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int d, input int w, input int b, input bit clr,
                            input bit en_a, input bit en_b, output int edge_c);
    i_data = 8'(d); i_weight = 8'(w); i_bias = 32'(b);
    i_clear = clr; val_a = en_a; val_b = en_b;
    @(posedge clk);
    #1;
    edge_c = cyc;
    val_a = 1'b0; val_b = 1'b0; i_clear = 1'b0;
    if (clr) begin
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      if (en_a) model_beat(0, d, w, b);
      if (en_b) model_beat(1, d, w, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (o_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid_a); end
    checks++; if (o_acc_a !== 32'd0) begin errors++; $display("FAIL reset_acc: got %0d want 0", o_acc_a); end
    checks++; if (o_bias_a !== 32'd0) begin errors++; $display("FAIL reset_bias: got %0d want 0", o_bias_a); end
    checks++; if (o_busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy_a); end
    rst = 1'b0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    clear_q();
    idle(1);
  endtask

  task automatic test_basic();
    int e;
    clear_q();
    for (int i = 0; i < 4; i++) drive_beat(i + 1, i + 5, 100, 1'b0, 1'b1, 1'b0, e);
    idle(4);
    checks++; if (got_acc_a.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d pulses want 1", got_acc_a.size()); end
    if (got_acc_a.size() >= 1) begin
      checks++; if (got_acc_a[0] !== 70) begin errors++; $display("FAIL basic_acc: got %0d want 70", got_acc_a[0]); end
      checks++; if (got_bias_a[0] !== 100) begin errors++; $display("FAIL basic_bias: got %0d want 100", got_bias_a[0]); end
      checks++; if (got_cyc_a[0] !== e + 1) begin errors++; $display("FAIL basic_latency: pulse at %0d want %0d", got_cyc_a[0], e + 1); end
    end
  endtask

  task automatic test_gaps();
    int e;
    for (int rep = 0; rep < 3; rep++) begin
      clear_q();
      for (int i = 0; i < 4; i++) begin
        idle($urandom_range(0, 3));
        drive_beat(i + 1, i + 5, 100, 1'b0, 1'b1, 1'b0, e);
      end
      idle(4);
      checks++; if (got_acc_a.size() !== 1) begin errors++; $display("FAIL gaps_count: got %0d pulses want 1", got_acc_a.size()); end
      if (got_acc_a.size() >= 1) begin
        checks++; if (got_acc_a[0] !== 70) begin errors++; $display("FAIL gaps_acc: got %0d want 70", got_acc_a[0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    clear_q();
    for (int i = 0; i < 4; i++) drive_beat(-128, -128, -5, 1'b0, 1'b1, 1'b0, e);
    for (int i = 0; i < 4; i++) drive_beat(127, -128, 7, 1'b0, 1'b1, 1'b0, e);
    idle(4);
    checks++; if (got_acc_a.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d pulses want 2", got_acc_a.size()); end
    if (got_acc_a.size() >= 2) begin
      checks++; if (got_acc_a[0] !== 65536) begin errors++; $display("FAIL b2b_acc0: got %0d want 65536", got_acc_a[0]); end
      checks++; if (got_bias_a[0] !== -5) begin errors++; $display("FAIL b2b_bias0: got %0d want -5", got_bias_a[0]); end
      checks++; if (got_acc_a[1] !== -65024) begin errors++; $display("FAIL b2b_acc1: got %0d want -65024", got_acc_a[1]); end
      checks++; if (got_bias_a[1] !== 7) begin errors++; $display("FAIL b2b_bias1: got %0d want 7", got_bias_a[1]); end
      checks++; if (got_cyc_a[1] - got_cyc_a[0] !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", got_cyc_a[1] - got_cyc_a[0]); end
    end
    checks++; if (o_busy_a !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", o_busy_a); end
  endtask

  task automatic test_clear();
    int e;
    clear_q();
    drive_beat(9, 9, 55, 1'b0, 1'b1, 1'b0, e);
    drive_beat(9, 9, 55, 1'b0, 1'b1, 1'b0, e);
    drive_beat(9, 9, 55, 1'b1, 1'b1, 1'b0, e);
    checks++; if (o_busy_a !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", o_busy_a); end
    for (int i = 0; i < 4; i++) drive_beat(1, 1, 11, 1'b0, 1'b1, 1'b0, e);
    idle(4);
    checks++; if (got_acc_a.size() !== 1) begin errors++; $display("FAIL clear_count: got %0d pulses want 1", got_acc_a.size()); end
    if (got_acc_a.size() >= 1) begin
      checks++; if (got_acc_a[0] !== 4) begin errors++; $display("FAIL clear_acc: got %0d want 4", got_acc_a[0]); end
      checks++; if (got_bias_a[0] !== 11) begin errors++; $display("FAIL clear_bias: got %0d want 11", got_bias_a[0]); end
    end
  endtask

  task automatic test_wrap();
    int e;
    clear_q();
    for (int i = 0; i < 8; i++) drive_beat(127, 127, 3, 1'b0, 1'b0, 1'b1, e);
    idle(4);
    checks++; if (got_acc_b.size() !== exp_acc_b.size()) begin errors++; $display("FAIL wrap_count: got %0d pulses want %0d", got_acc_b.size(), exp_acc_b.size()); end
    for (int i = 0; i < exp_acc_b.size() && i < got_acc_b.size(); i++) begin
      checks++; if (got_acc_b[i] !== exp_acc_b[i]) begin errors++; $display("FAIL wrap_acc: got %0d want %0d", got_acc_b[i], exp_acc_b[i]); end
      checks++; if (got_bias_b[i] !== exp_bias_b[i]) begin errors++; $display("FAIL wrap_bias: got %0d want %0d", got_bias_b[i], exp_bias_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int e;
    clear_q();
    drive_beat(3, 4, 1, 1'b0, 1'b1, 1'b0, e);
    drive_beat(3, 4, 1, 1'b0, 1'b1, 1'b0, e);
    checks++; if (o_busy_a !== 1'b1) begin errors++; $display("FAIL midvec_busy: got %b want 1", o_busy_a); end
    rst = 1'b1;
    #1;
    checks++; if (o_busy_a !== 1'b0) begin errors++; $display("FAIL midvec_rst_busy: got %b want 0", o_busy_a); end
    checks++; if (o_acc_a !== 32'd0) begin errors++; $display("FAIL midvec_rst_acc: got %0d want 0", o_acc_a); end
    rst = 1'b0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    idle(1);
    for (int i = 0; i < 4; i++) drive_beat(2, 3, 9, 1'b0, 1'b1, 1'b0, e);
    rst = 1'b1;
    #1;
    checks++; if (o_valid_a !== 1'b0) begin errors++; $display("FAIL stage2_rst_valid: got %b want 0", o_valid_a); end
    checks++; if (o_bias_a !== 32'd0) begin errors++; $display("FAIL stage2_rst_bias: got %0d want 0", o_bias_a); end
    idle(2);
    rst = 1'b0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    clear_q();
    idle(3);
    checks++; if (got_acc_a.size() !== 0) begin errors++; $display("FAIL stage2_rst_pulse: got %0d pulses want 0", got_acc_a.size()); end
    for (int i = 0; i < 4; i++) drive_beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 21, 1'b0, 1'b1, 1'b0, e);
    idle(4);
    checks++; if (got_acc_a.size() !== exp_acc_a.size()) begin errors++; $display("FAIL post_rst_count: got %0d want %0d", got_acc_a.size(), exp_acc_a.size()); end
    for (int i = 0; i < exp_acc_a.size() && i < got_acc_a.size(); i++) begin
      checks++; if (got_acc_a[i] !== exp_acc_a[i]) begin errors++; $display("FAIL post_rst_acc: got %0d want %0d", got_acc_a[i], exp_acc_a[i]); end
      checks++; if (got_bias_a[i] !== exp_bias_a[i]) begin errors++; $display("FAIL post_rst_bias: got %0d want %0d", got_bias_a[i], exp_bias_a[i]); end
    end
  endtask

  task automatic test_random();
    int e;
    clear_q();
    for (int n = 0; n < 400; n++) begin
      idle($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0);
      drive_beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                 int'($urandom), ($urandom_range(0, 24) == 0), 1'b1, 1'b1, e);
    end
    idle(5);
    checks++; if (got_acc_a.size() !== exp_acc_a.size()) begin errors++; $display("FAIL rand_count_a: got %0d want %0d", got_acc_a.size(), exp_acc_a.size()); end
    for (int i = 0; i < exp_acc_a.size() && i < got_acc_a.size(); i++) begin
      checks++; if (got_acc_a[i] !== exp_acc_a[i]) begin errors++; $display("FAIL rand_acc_a[%0d]: got %0d want %0d", i, got_acc_a[i], exp_acc_a[i]); end
      checks++; if (got_bias_a[i] !== exp_bias_a[i]) begin errors++; $display("FAIL rand_bias_a[%0d]: got %0d want %0d", i, got_bias_a[i], exp_bias_a[i]); end
    end
    checks++; if (got_acc_b.size() !== exp_acc_b.size()) begin errors++; $display("FAIL rand_count_b: got %0d want %0d", got_acc_b.size(), exp_acc_b.size()); end
    for (int i = 0; i < exp_acc_b.size() && i < got_acc_b.size(); i++) begin
      checks++; if (got_acc_b[i] !== exp_acc_b[i]) begin errors++; $display("FAIL rand_acc_b[%0d]: got %0d want %0d", i, got_acc_b[i], exp_acc_b[i]); end
      checks++; if (got_bias_b[i] !== exp_bias_b[i]) begin errors++; $display("FAIL rand_bias_b[%0d]: got %0d want %0d", i, got_bias_b[i], exp_bias_b[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
